fifo_uart_tx: RTL and testbench

- Downstream consumer of the synchronous FIFO.
- Pops one word at a time through the FIFO read port (r_en / empty / registered data_out, 1-cycle read latency).
- Serializes each word as an asynchronous UART frame on `tx`: start bit, data bits LSB first, optional parity, then stop bit(s).
- Sits between the FIFO and the pad/serial line.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 23 ++
 rtl/fifo_uart_tx.sv | 122 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Total clk cycles of one frame from the start-bit edge to the end of the last stop bit.
  function automatic int unsigned frame_cycles(input int unsigned data_width,
                                               input int unsigned parity_en,
                                               input int unsigned stop_bits,
                                               input int unsigned clks_per_bit);
    return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
  endfunction

  // Zero-extended data does not change the XOR, so one wide argument serves every width.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: pulses bit_end on the last clk of each serial bit while run is high.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !run || cnt == LAST) cnt <= '0;
    else                               cnt <= cnt + CNT_W'(1);
  end

  assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serializes each one as a UART frame on tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  parity_bit;
  logic [IDX_W-1:0]      bit_idx;
  logic                  run;
  logic                  bit_end;

  assign run       = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign fifo_r_en = rst_n && (state == IDLE) && enable && !fifo_empty;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .bit_end (bit_end)
  );

  // tx always carries the value of the bit currently on the line; it changes at bit_end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      bit_idx    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_r_en) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shreg      <= fifo_data;
          parity_bit <= calc_parity(MAX_DATA_WIDTH'(fifo_data), PARITY_ODD != 0);
          tx         <= 1'b0;
          state      <= START;
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: four transmitter configurations fed by a queue-based FIFO model.
module tb_fifo_uart_tx;

  localparam int NI  = 4;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic [NI-1:0] rst_n;
  logic [NI-1:0] enable;
  logic [NI-1:0] fempty = '1;
  logic [NI-1:0] r_en;
  logic [NI-1:0] tx;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [7:0]    fdata = 8'h00;

  always #5 clk = ~clk;

  // inst0 default, inst1 even parity, inst2 odd parity, inst3 two stop bits
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .fifo_empty(fempty[0]), .fifo_r_en(r_en[0]),
    .fifo_data(fdata), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .fifo_empty(fempty[1]), .fifo_r_en(r_en[1]),
    .fifo_data(fdata), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .enable(enable[2]), .fifo_empty(fempty[2]), .fifo_r_en(r_en[2]),
    .fifo_data(fdata), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n[3]), .enable(enable[3]), .fifo_empty(fempty[3]), .fifo_r_en(r_en[3]),
    .fifo_data(fdata), .tx(tx[3]), .busy(busy[3]), .tx_done(done[3]));

  // FIFO model: only the selected instance sees a non-empty FIFO; data_out is registered.
  logic [7:0]    q[$];
  int            sel = 0;
  logic [NI-1:0] ren_cap = '0;
  int            underflow = 0;

  always @(negedge clk) ren_cap <= r_en;

  always @(posedge clk) begin
    int n;
    n = q.size();
    if ((ren_cap & fempty) != '0) underflow++;
    if (ren_cap[sel] && n > 0) begin
      fdata <= q.pop_front();
      n--;
    end
    for (int i = 0; i < NI; i++) fempty[i] <= !(i == sel && n > 0);
  end

  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int pen(input int i);   return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int podd(input int i);  return (i == 2) ? 1 : 0;           endfunction
  function automatic int nstop(input int i); return (i == 3) ? 2 : 1;           endfunction
  function automatic int flen(input int i);  return (1 + 8 + pen(i) + nstop(i)) * CPB; endfunction

  // Line level of serial bit k of a frame carrying byte b.
  function automatic logic bitval(input int i, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pen(i) == 1 && k == 9) return (^b) ^ (podd(i) == 1);
    return 1'b1;
  endfunction

  logic [7:0] exp_b[8];
  int         exp_n;
  int         m_fall, m_done, m_busy, m_par, m_gap;

  task automatic wait_ren(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (r_en[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL ren_timeout inst%0d: got no fifo_r_en within 20 cycles, expected one", i);
    end
  endtask

  // Checks exp_n frames cycle by cycle against the ideal frame timeline starting at the fetch cycle.
  task automatic run_frames(input int i, input int drop_at);
    bit         ok;
    int         p, total, f, pos, run_hi;
    logic [3:0] got, e;
    logic       e_tx;
    sel       = i;
    enable[i] = 1'b1;
    #1;
    wait_ren(i, ok);
    if (!ok) return;
    p = flen(i) + 2;
    total = exp_n * p + 8;
    m_fall = -1; m_done = -1; m_busy = 0; m_par = -1; m_gap = -1; run_hi = 0;
    for (int c = 0; c < total; c++) begin
      f   = c / p;
      pos = c % p;
      if (f < exp_n) begin
        e_tx = (pos < 2) ? 1'b1 : bitval(i, exp_b[f], (pos - 2) / CPB);
        e = {pos == 0, e_tx, pos != 0, pos == 0 && f > 0};
      end else begin
        e = {1'b0, 1'b1, 1'b0, c == exp_n * p};
      end
      got = {r_en[i], tx[i], busy[i], done[i]};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL frame inst%0d cyc%0d: got ren/tx/busy/done=%b expected %b", i, c, got, e);
      end
      if (f == 0 && busy[i]) m_busy++;
      if (!tx[i] && m_fall < 0) m_fall = c;
      if (done[i] && m_done < 0) m_done = c;
      if (f == 0 && pos == 2 + 9 * CPB + CPB / 2) m_par = int'(tx[i]);
      if (tx[i]) run_hi++;
      else begin
        if (f == 1 && pos == 2 && m_gap < 0) m_gap = run_hi;
        run_hi = 0;
      end
      if (c == drop_at) enable[i] = 1'b0;
      tick();
    end
    enable[i] = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       has;
    logic [3:0] exp;   // {fifo_r_en, tx, busy, tx_done}
  } vec_t;

  initial begin
    vec_t vt[6];
    bit   ok;
    int   viol;

    vt[0] = '{1'b0, 1'b1, 1'b1, 4'b0100};
    vt[1] = '{1'b0, 1'b0, 1'b0, 4'b0100};
    vt[2] = '{1'b1, 1'b1, 1'b0, 4'b0100};
    vt[3] = '{1'b1, 1'b0, 1'b0, 4'b0100};
    vt[4] = '{1'b1, 1'b0, 1'b1, 4'b0100};
    vt[5] = '{1'b1, 1'b1, 1'b1, 4'b1100};

    rst_n  = '0;
    enable = '0;
    repeat (3) tick();
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_state inst%0d", i), int'({r_en[i], tx[i], busy[i], done[i]}), 32'h4);

    // IDLE fetch decision table on inst0; the last row fetches 0xA5 and starts the first frame.
    for (int v = 0; v < 6; v++) begin
      q.delete();
      if (vt[v].has) q.push_back(8'hA5);
      tick();
      rst_n[0]  = vt[v].rst;
      enable[0] = vt[v].en;
      #1;
      chk($sformatf("idle_vec%0d", v), int'({r_en[0], tx[0], busy[0], done[0]}), int'(vt[v].exp));
    end

    exp_b[0] = 8'hA5; exp_n = 1;
    run_frames(0, -1);
    chk("a5_fall_offset", m_fall, 2);
    chk("a5_done_after_fall", m_done - m_fall, 160);
    chk("a5_busy_cycles", m_busy, 161);

    rst_n = '1;
    repeat (2) tick();

    q.push_back(8'h3C); q.push_back(8'hC3);
    exp_b[0] = 8'h3C; exp_b[1] = 8'hC3; exp_n = 2;
    run_frames(0, -1);
    chk("b2b_high_gap", m_gap, 18);

    q.push_back(8'h07); exp_b[0] = 8'h07; exp_n = 1;
    run_frames(1, -1);
    chk("even_parity_bit", m_par, 1);
    chk("even_frame_len", m_done - m_fall, 176);

    q.push_back(8'h07); exp_b[0] = 8'h07; exp_n = 1;
    run_frames(2, -1);
    chk("odd_parity_bit", m_par, 0);
    chk("odd_frame_len", m_done - m_fall, 176);

    q.push_back(8'h55); q.push_back(8'h12);
    exp_b[0] = 8'h55; exp_b[1] = 8'h12; exp_n = 2;
    run_frames(3, -1);
    chk("stop2_high_gap", m_gap, 34);

    // Empty FIFO with every instance enabled.
    sel = 0;
    enable = '1;
    viol = 0;
    repeat (500) begin
      tick();
      for (int i = 0; i < NI; i++)
        if ({r_en[i], tx[i], busy[i], done[i]} !== 4'b0100) viol++;
    end
    chk("empty_idle_violations", viol, 0);
    enable = '0;
    tick();

    for (int i = 0; i < NI; i++) begin
      exp_n = int'($urandom_range(1, 3));
      for (int k = 0; k < exp_n; k++) begin
        exp_b[k] = 8'($urandom);
        q.push_back(exp_b[k]);
      end
      run_frames(i, -1);
    end

    // enable dropped during DATA: frame completes, second word stays queued.
    q.push_back(8'h96); q.push_back(8'h3A);
    exp_b[0] = 8'h96; exp_n = 1;
    run_frames(0, 60);
    chk("enable_drop_queue_left", q.size(), 1);
    q.delete();
    repeat (2) tick();

    // One-cycle reset during DATA aborts the frame; the next queued word then goes out cleanly.
    q.push_back(8'h5A); q.push_back(8'h81);
    sel = 0;
    enable[0] = 1'b1;
    #1;
    wait_ren(0, ok);
    repeat (60) tick();
    chk("pre_reset_busy", int'(busy[0]), 1);
    rst_n[0] = 1'b0;
    tick();
    chk("mid_reset_outputs", int'({r_en[0], tx[0], busy[0], done[0]}), 32'h4);
    enable[0] = 1'b0;
    rst_n[0]  = 1'b1;
    viol = 0;
    repeat (5) begin
      tick();
      if ({tx[0], busy[0], done[0]} !== 3'b100) viol++;
    end
    chk("post_reset_quiet", viol, 0);
    exp_b[0] = 8'h81; exp_n = 1;
    run_frames(0, -1);
    chk("post_reset_frame_len", m_done - m_fall, 160);

    chk("fifo_underflow", underflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
